// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised single-port data RAM:
// controller state encoding and the default geometry constants.
package ram_pkg;

  // Controller states: sweeping the array, or serving requests.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } ram_state_t;

  // Defaults reproduce the original 12 x 8 scratch RAM.
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 12;

  // Index width needed to address 'depth' words (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_sp_core.sv
// Bare storage array for ram_sp_param: one shared address, one write port and
// a registered read port. Addresses at or beyond DEPTH never touch the array;
// such reads load zero into the read register instead.
module ram_sp_core
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = idx_width(DEPTH);
  // One extra bit so that DEPTH = 2^ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic              addr_ok;
  logic [IDX_W-1:0]  idx;

  assign addr_ok = ({1'b0, addr} < DEPTH_X);
  assign idx     = addr[IDX_W-1:0];

  // Array write; the array itself has no reset, the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (we && addr_ok) begin
      mem[idx] <= wdata;
    end
  end

  // Registered read port; holds its value until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= addr_ok ? mem[idx] : '0;
    end
  end

endmodule

// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous data RAM with request/valid handshake,
// hardware clear sweep and out-of-range detection.
//
// Optional build macro RAM_SP_PARAM_OUTREG_EN: adds an output register stage,
// making read latency 2 cycles (valid and err travel with the data). Without
// the macro, read latency is 1 cycle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | writing INIT_VAL to mem[ptr] each cycle; busy, requests ignored
// ST_IDLE  | accepting a request on every edge where req = 1
module ram_sp_param
  import ram_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DEPTH    = DEPTH_DEF,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic              clr,
  input  logic [ADDR_W-1:0] dir,
  input  logic [DATA_W-1:0] dato_e,
  output logic [DATA_W-1:0] dato_s,
  output logic              valid,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = (ADDR_W)'(DEPTH - 1);

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  logic              in_range;
  logic [ADDR_W-1:0] core_addr;
  logic              core_we;
  logic [DATA_W-1:0] core_wdata;
  logic              core_re;
  logic [DATA_W-1:0] core_rdata;

  logic              valid_d, err_d;
  logic              valid_q1, err_q1;

  // Compared at ADDR_W+1 bits so a full-size array never flags an error.
  assign in_range = ({1'b0, dir} < DEPTH_X);

  // Next-state and array-control decode; clr takes priority over req.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    core_addr  = dir;
    core_we    = 1'b0;
    core_wdata = dato_e;
    core_re    = 1'b0;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        core_addr  = ptr_q;
        core_we    = 1'b1;
        core_wdata = INIT_VAL;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else if (req) begin
          core_we = we && in_range;
          core_re = !we;
          valid_d = !we;
          err_d   = !in_range;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // State and sweep pointer; reset parks the FSM at the start of a sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Handshake flags aligned with the registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q1 <= 1'b0;
      err_q1   <= 1'b0;
    end else begin
      valid_q1 <= valid_d;
      err_q1   <= err_d;
    end
  end

  ram_sp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .addr  (core_addr),
    .we    (core_we),
    .wdata (core_wdata),
    .re    (core_re),
    .rdata (core_rdata)
  );

  assign busy = (state_q == ST_CLEAR);

`ifdef RAM_SP_PARAM_OUTREG_EN
  logic [DATA_W-1:0] dato_q2;
  logic              valid_q2, err_q2;

  // Extra output stage; not flushed by clr, so an in-flight read still lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dato_q2  <= '0;
      valid_q2 <= 1'b0;
      err_q2   <= 1'b0;
    end else begin
      valid_q2 <= valid_q1;
      err_q2   <= err_q1;
      if (valid_q1) begin
        dato_q2 <= core_rdata;
      end
    end
  end

  assign dato_s = dato_q2;
  assign valid  = valid_q2;
  assign err    = err_q2;
`else
  assign dato_s = core_rdata;
  assign valid  = valid_q1;
  assign err    = err_q1;
`endif

endmodule

// File: tb/tb_ram_sp_param.sv
// Self-checking bench for ram_sp_param with default geometry: directed steps
// followed by random traffic, compared against a behavioural model.
module tb_ram_sp_param;
  import ram_pkg::*;

  localparam int DATA_W = DATA_W_DEF;
  localparam int ADDR_W = ADDR_W_DEF;
  localparam int DEPTH  = DEPTH_DEF;
`ifdef RAM_SP_PARAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic              we  = 1'b0;
  logic              clr = 1'b0;
  logic [ADDR_W-1:0] dir    = '0;
  logic [DATA_W-1:0] dato_e = '0;
  logic [DATA_W-1:0] dato_s;
  logic              valid, busy, err;

  always #5 clk = ~clk;

  ram_sp_param dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .clr    (clr),
    .dir    (dir),
    .dato_e (dato_e),
    .dato_s (dato_s),
    .valid  (valid),
    .busy   (busy),
    .err    (err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic              v;
    logic              e;
    logic [DATA_W-1:0] d;
  } ev_t;

  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_busy;
  logic [DATA_W-1:0] m_dato;
  ev_t               m_pipe [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = '0;
    m_busy = DEPTH;
    m_dato = '0;
    m_pipe.delete();
    for (int i = 0; i < LAT - 1; i++) m_pipe.push_back('0);
  endtask

  // Hold rst across one edge; outputs must show reset values at once.
  task automatic do_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; clr = 1'b0;
    #1;
    chk("rst_dato", 32'(dato_s), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one cycle of inputs, advance one edge, update model, check outputs.
  task automatic step(input logic r, input logic w, input logic c,
                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ev_t ev;
    int  ai;
    ev = '0;
    ai = int'(a);
    req = r; we = w; clr = c; dir = a; dato_e = d;
    @(posedge clk); #1;
    if (m_busy > 0) begin
      m_busy--;
    end else if (c) begin
      m_busy = DEPTH;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else if (r) begin
      if (ai < DEPTH) begin
        if (w) m_mem[ai] = d;
        else   ev.d = m_mem[ai];
      end
      ev.v = !w;
      ev.e = (ai >= DEPTH);
    end
    m_pipe.push_back(ev);
    ev = m_pipe.pop_front();
    if (ev.v) m_dato = ev.d;
    req = 1'b0; we = 1'b0; clr = 1'b0;
    chk("valid", 32'(valid), 32'(ev.v));
    chk("err", 32'(err), 32'(ev.e));
    chk("dato_s", 32'(dato_s), 32'(m_dato));
    chk("busy", 32'(busy), 32'(m_busy > 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Power-up sweep, then every word reads as zero.
    idle(DEPTH);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, ADDR_W'(i), '0);
    idle(LAT);

    // Write then immediate read; back-to-back reads.
    step(1'b1, 1'b1, 1'b0, 8'd3, 8'd90);
    step(1'b1, 1'b0, 1'b0, 8'd3, '0);
    step(1'b1, 1'b0, 1'b0, 8'd3, '0);
    step(1'b1, 1'b0, 1'b0, 8'd4, '0);
    idle(LAT);

    // Out-of-range write and read, neighbouring word untouched.
    step(1'b1, 1'b1, 1'b0, 8'd12, 8'd55);
    step(1'b1, 1'b0, 1'b0, 8'd200, '0);
    step(1'b1, 1'b0, 1'b0, 8'd11, '0);
    step(1'b1, 1'b0, 1'b0, 8'd255, '0);
    idle(LAT);

    // clr wins over a simultaneous read, then the word reads back cleared.
    step(1'b1, 1'b1, 1'b0, 8'd5, 8'hAA);
    step(1'b1, 1'b0, 1'b1, 8'd5, '0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, 8'd5, '0);
    step(1'b1, 1'b0, 1'b0, 8'd5, '0);
    idle(LAT);

    // Read in flight when clr arrives still delivers.
    step(1'b1, 1'b1, 1'b0, 8'd7, 8'h3C);
    step(1'b1, 1'b0, 1'b0, 8'd7, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    idle(DEPTH + 1);

    // Reset in the middle of a sweep restarts it from scratch.
    do_reset();
    idle(6);
    do_reset();
    idle(DEPTH + 1);

    // Latency of a plain write/read pair.
    step(1'b1, 1'b1, 1'b0, 8'd2, 8'd70);
    step(1'b1, 1'b0, 1'b0, 8'd2, '0);
    idle(LAT + 1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic              r, w, c;
      logic [ADDR_W-1:0] a;
      r = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) == 1;
      c = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) a = ADDR_W'($urandom);
      else                           a = ADDR_W'($urandom_range(0, 15));
      step(r, w, c, a, DATA_W'($urandom));
    end
    idle(LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
